// File: rtl/softmax_max_sub.sv
// -----------------------------------------------------------------------------
// softmax_max_sub
//
// Softmax front-end stage placed directly in front of pla_exp_pipelined.
// It buffers one score vector of VEC_LEN signed Q5.26 words and tracks the
// running maximum while the vector loads. It then hands each (x_i - max) to
// the exp unit, one element per start/done handshake. Every exp argument is
// therefore <= 0, which keeps exp() inside its accurate range.
//
// Handshakes:
//   Input side is valid/ready. A word transfers on a rising edge where
//   in_valid & in_ready are both high. in_valid may drop at any time, and the
//   stage simply waits for the next word. in_ready depends only on state and
//   rst_n, never on in_valid.
//   Exp side is start/done. exp_start is a one-cycle pulse that is only
//   raised after exp_busy was seen low. exp_x_q stays stable from that pulse
//   until exp_done. exp_done is honoured only while waiting for a result.
//
// Ports:
//   clk, rst_n   clock (rising edge), synchronous active-low reset
//   in_valid     score word valid
//   in_ready     stage accepts a score word (IDLE/LOAD, out of reset)
//   in_data      signed Q5.26 score
//   exp_start    one-cycle start pulse to the exp unit
//   exp_x_q      signed Q5.26 exp argument (x_i - max), saturated
//   exp_busy     exp unit busy
//   exp_done     exp unit result ready (one-cycle pulse)
//   max_q        max of the current vector
//   busy         high in every state except IDLE
//   row_done     one-cycle pulse after the last element's exp_done
// -----------------------------------------------------------------------------
module softmax_max_sub #(
  parameter int W       = 32,
  parameter int Q       = 26,
  parameter int VEC_LEN = 64,
  parameter int CNT_W   = $clog2(VEC_LEN) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         exp_start,
  output logic [W-1:0] exp_x_q,
  input  logic         exp_busy,
  input  logic         exp_done,
  output logic [W-1:0] max_q,
  output logic         busy,
  output logic         row_done
);

  // Q only documents the fixed-point format. No scaling happens here, but a
  // format with no integer bits cannot hold a score.
  if (VEC_LEN < 1 || Q >= W) begin : g_bad_params
    $error("softmax_max_sub: need VEC_LEN >= 1 and Q < W");
  end

  localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [W-1:0]       vec_buf [VEC_LEN];

  logic               xfer;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic [W-1:0]       rd_word;
  logic [W:0]         diff;
  logic [W-1:0]       diff_sat;

  assign xfer   = in_valid & in_ready;
  assign rd_idx = cnt_q[IDX_W-1:0];

  // In IDLE, cnt_q still holds the previous vector's last index, so the
  // first word of a new vector is steered to slot 0 explicitly.
  assign wr_idx  = (state_q == S_IDLE) ? '0 : rd_idx;
  assign rd_word = vec_buf[rd_idx];

  // Subtract one bit wider than the data. max_q >= every buffered word, so
  // the result can only overflow downward. That case shows as sign bit set
  // and bit W-1 clear, and it clamps to the most negative word.
  assign diff     = {rd_word[W-1], rd_word} - {max_q[W-1], max_q};
  assign diff_sat = (diff[W] && !diff[W-1]) ? {1'b1, {(W-1){1'b0}}}
                                            : diff[W-1:0];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (xfer) state_d = (VEC_LEN == 1) ? S_ISSUE : S_LOAD;
      S_LOAD:  if (xfer && cnt_q == LAST) state_d = S_ISSUE;
      S_ISSUE: if (!exp_busy) state_d = S_WAIT;
      S_WAIT:  if (exp_done) state_d = (cnt_q == LAST) ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    row_done = 1'b0;
    case (state_q)
      S_IDLE:  in_ready = rst_n;
      S_LOAD: begin
        in_ready = rst_n;
        busy     = 1'b1;
      end
      S_ISSUE: busy = 1'b1;
      S_WAIT:  busy = 1'b1;
      S_DONE: begin
        busy     = 1'b1;
        row_done = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: index counter, running max, exp argument and start pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      max_q     <= '0;
      exp_x_q   <= '0;
      exp_start <= 1'b0;
    end else begin
      exp_start <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            max_q <= in_data;
            cnt_q <= (VEC_LEN == 1) ? '0 : CNT_W'(1);
          end
        end
        S_LOAD: begin
          if (xfer) begin
            if ($signed(in_data) > $signed(max_q)) max_q <= in_data;
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
          end
        end
        S_ISSUE: begin
          if (!exp_busy) begin
            exp_start <= 1'b1;
            exp_x_q   <= diff_sat;
          end
        end
        S_WAIT: begin
          if (exp_done && cnt_q != LAST) cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Score storage is not reset. Every slot is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (xfer) vec_buf[wr_idx] <= in_data;
  end

endmodule

// File: tb/tb_softmax_max_sub.sv
// -----------------------------------------------------------------------------
// Bench for softmax_max_sub (VEC_LEN = 4).
// A responder process on the falling edge plays the exp unit. It records
// every exp argument and raises done after a random latency.
// -----------------------------------------------------------------------------
module tb_softmax_max_sub;
  localparam int W  = 32;
  localparam int VL = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         exp_busy = 1'b0;
  logic         exp_done = 1'b0;
  logic         in_ready, exp_start, busy, row_done;
  logic [W-1:0] exp_x_q, max_q;

  always #5 clk = ~clk;

  softmax_max_sub #(.W(W), .Q(26), .VEC_LEN(VL)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .exp_start(exp_start), .exp_x_q(exp_x_q),
    .exp_busy(exp_busy), .exp_done(exp_done),
    .max_q(max_q), .busy(busy), .row_done(row_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  logic [W-1:0] vec [VL];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] exp_max;

  task automatic build_expect();
    longint m;
    longint d;
    logic [63:0] bits;
    m = longint'($signed(vec[0]));
    for (int i = 1; i < VL; i++)
      if (longint'($signed(vec[i])) > m) m = longint'($signed(vec[i]));
    bits = m;
    exp_max = bits[W-1:0];
    exp_q.delete();
    for (int i = 0; i < VL; i++) begin
      d = longint'($signed(vec[i])) - m;
      bits = d;
      if (d < -(64'sd1 <<< (W-1))) exp_q.push_back(32'h8000_0000);
      else exp_q.push_back(bits[W-1:0]);
    end
  endtask

  // ---------------- exp unit model / monitor ----------------
  int lat_lo = 1, lat_hi = 3, hold_hi = 0;
  int phase = 0, lat_cnt = 0, hold_cnt = 0;
  logic [W-1:0] held_x = '0;
  logic [W-1:0] got_q [$];
  int n_start = 0, n_row = 0, viol_busy = 0, viol_stable = 0, viol_ready = 0;
  bit issuing = 1'b0;
  bit tmo = 1'b0;

  always @(negedge clk) begin
    if (issuing && in_ready) viol_ready++;
    if (row_done) begin
      n_row++;
      issuing = 1'b0;
    end
    if (exp_start && exp_busy) viol_busy++;
    exp_done = 1'b0;
    case (phase)
      0: if (exp_start) begin
        n_start++;
        got_q.push_back(exp_x_q);
        held_x   = exp_x_q;
        exp_busy = 1'b1;
        lat_cnt  = int'($urandom_range(lat_hi, lat_lo));
        phase    = 1;
      end
      1: begin
        if (exp_x_q !== held_x) viol_stable++;
        lat_cnt--;
        if (lat_cnt <= 0) begin
          exp_done = 1'b1;
          hold_cnt = int'($urandom_range(hold_hi, 0));
          phase    = 2;
        end
      end
      default: begin
        if (hold_cnt == 0) begin
          exp_busy = 1'b0;
          phase    = 0;
        end else hold_cnt--;
      end
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    got_q.delete();
    n_start = 0; n_row = 0;
    viol_busy = 0; viol_stable = 0; viol_ready = 0;
    tmo = 1'b0;
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic send_vector(input int gap_hi);
    for (int i = 0; i < VL; i++) begin
      int g;
      int t;
      g = int'($urandom_range(gap_hi, 0));
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = vec[i];
      t = 0;
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) tmo = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = $urandom;
    issuing  = 1'b1;
  endtask

  task automatic wait_row();
    int t;
    t = 0;
    while ((n_row == 0 || phase != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) tmo = 1'b1;
  endtask

  task automatic run_vector(input int gap_hi);
    clear_obs();
    build_expect();
    send_vector(gap_hi);
    wait_row();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (exp_start !== 1'b0) begin n_bad++; $display("FAIL rst_exp_start: got %b want 0", exp_start); end
    n_cmp++; if (exp_x_q !== '0) begin n_bad++; $display("FAIL rst_exp_x: got %h want 0", exp_x_q); end
    n_cmp++; if (max_q !== '0) begin n_bad++; $display("FAIL rst_max: got %h want 0", max_q); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (row_done !== 1'b0) begin n_bad++; $display("FAIL rst_row_done: got %b want 0", row_done); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    vec[0] = 32'h0400_0000; vec[1] = 32'h0C00_0000; vec[2] = 32'hF800_0000; vec[3] = 32'h0200_0000;
    lat_lo = 1; lat_hi = 3; hold_hi = 0;
    run_vector(0);
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL t1_timeout: got %b want 0", tmo); end
    n_cmp++; if (max_q !== exp_max) begin n_bad++; $display("FAIL t1_max: got %h want %h", max_q, exp_max); end
    n_cmp++; if (got_q.size() != VL) begin n_bad++; $display("FAIL t1_starts: got %0d want %0d", got_q.size(), VL); end
    for (int i = 0; i < VL; i++) begin
      logic [W-1:0] g;
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_cmp++; if (g !== exp_q[i]) begin n_bad++; $display("FAIL t1_x[%0d]: got %h want %h", i, g, exp_q[i]); end
    end
    n_cmp++; if (n_row != 1) begin n_bad++; $display("FAIL t1_row_done: got %0d want 1", n_row); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t1_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_ties();
    for (int i = 0; i < VL; i++) vec[i] = 32'h0A00_0000;
    run_vector(0);
    n_cmp++; if (max_q !== exp_max) begin n_bad++; $display("FAIL t2_max: got %h want %h", max_q, exp_max); end
    n_cmp++; if (got_q.size() != VL || tmo) begin n_bad++; $display("FAIL t2_starts: got %0d want %0d", got_q.size(), VL); end
    for (int i = 0; i < VL; i++) begin
      logic [W-1:0] g;
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_cmp++; if (g !== exp_q[i]) begin n_bad++; $display("FAIL t2_x[%0d]: got %h want %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_saturate();
    vec[0] = 32'h7FFF_FFFF; vec[1] = 32'h8000_0000; vec[2] = 32'h0000_0000; vec[3] = 32'h7FFF_FFFF;
    run_vector(0);
    n_cmp++; if (max_q !== exp_max) begin n_bad++; $display("FAIL t3_max: got %h want %h", max_q, exp_max); end
    n_cmp++; if (got_q.size() != VL || tmo) begin n_bad++; $display("FAIL t3_starts: got %0d want %0d", got_q.size(), VL); end
    for (int i = 0; i < VL; i++) begin
      logic [W-1:0] g;
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_cmp++; if (g !== exp_q[i]) begin n_bad++; $display("FAIL t3_x[%0d]: got %h want %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_exp_latency();
    lat_lo = 1; lat_hi = 20; hold_hi = 5;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < VL; i++) vec[i] = $urandom;
      run_vector(2);
      n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL t4_timeout[%0d]: got %b want 0", r, tmo); end
      n_cmp++; if (n_start != VL) begin n_bad++; $display("FAIL t4_starts[%0d]: got %0d want %0d", r, n_start, VL); end
      n_cmp++; if (viol_busy != 0) begin n_bad++; $display("FAIL t4_start_while_busy[%0d]: got %0d want 0", r, viol_busy); end
      n_cmp++; if (viol_stable != 0) begin n_bad++; $display("FAIL t4_x_unstable[%0d]: got %0d want 0", r, viol_stable); end
      n_cmp++; if (viol_ready != 0) begin n_bad++; $display("FAIL t4_ready_in_issue[%0d]: got %0d want 0", r, viol_ready); end
      n_cmp++; if (max_q !== exp_max) begin n_bad++; $display("FAIL t4_max[%0d]: got %h want %h", r, max_q, exp_max); end
      for (int i = 0; i < VL; i++) begin
        logic [W-1:0] g;
        g = (i < got_q.size()) ? got_q[i] : 'x;
        n_cmp++; if (g !== exp_q[i]) begin n_bad++; $display("FAIL t4_x[%0d][%0d]: got %h want %h", r, i, g, exp_q[i]); end
      end
    end
    lat_lo = 1; lat_hi = 3; hold_hi = 0;
  endtask

  task automatic test_reset_mid();
    int t;
    int row0;
    vec[0] = 32'h0400_0000; vec[1] = 32'h0C00_0000; vec[2] = 32'hF800_0000; vec[3] = 32'h0200_0000;
    lat_lo = 8; lat_hi = 8; hold_hi = 0;
    clear_obs();
    send_vector(0);
    t = 0;
    while (!(n_start == 2 && phase == 1) && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_cmp++; if (t >= 500) begin n_bad++; $display("FAIL t5_reach_wait: got timeout want element 2 in flight"); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t5_busy: got %b want 0", busy); end
    n_cmp++; if (exp_start !== 1'b0) begin n_bad++; $display("FAIL t5_exp_start: got %b want 0", exp_start); end
    n_cmp++; if (exp_x_q !== '0) begin n_bad++; $display("FAIL t5_exp_x: got %h want 0", exp_x_q); end
    n_cmp++; if (max_q !== '0) begin n_bad++; $display("FAIL t5_max: got %h want 0", max_q); end
    n_cmp++; if (row_done !== 1'b0) begin n_bad++; $display("FAIL t5_row_done: got %b want 0", row_done); end
    rst_n = 1'b1;
    issuing = 1'b0;
    row0 = n_row;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL t5_ready: got %b want 1", in_ready); end
    t = 0;
    while (phase != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    n_cmp++; if (n_row != row0 || busy !== 1'b0) begin n_bad++; $display("FAIL t5_late_done: got rows %0d busy %b want rows %0d busy 0", n_row, busy, row0); end
    lat_lo = 1; lat_hi = 3;
    vec[0] = 32'h0000_0000; vec[1] = 32'hFC00_0000; vec[2] = 32'h0800_0000; vec[3] = 32'h0400_0000;
    run_vector(0);
    n_cmp++; if (max_q !== exp_max) begin n_bad++; $display("FAIL t5_new_max: got %h want %h", max_q, exp_max); end
    n_cmp++; if (n_row != 1 || tmo) begin n_bad++; $display("FAIL t5_new_row: got %0d want 1", n_row); end
    for (int i = 0; i < VL; i++) begin
      logic [W-1:0] g;
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_cmp++; if (g !== exp_q[i]) begin n_bad++; $display("FAIL t5_x[%0d]: got %h want %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_input_gaps();
    vec[0] = 32'h0400_0000; vec[1] = 32'h0C00_0000; vec[2] = 32'hF800_0000; vec[3] = 32'h0200_0000;
    for (int r = 0; r < 2; r++) begin
      run_vector(7);
      n_cmp++; if (max_q !== exp_max) begin n_bad++; $display("FAIL t6_max[%0d]: got %h want %h", r, max_q, exp_max); end
      n_cmp++; if (n_row != 1 || tmo) begin n_bad++; $display("FAIL t6_row[%0d]: got %0d want 1", r, n_row); end
      for (int i = 0; i < VL; i++) begin
        logic [W-1:0] g;
        g = (i < got_q.size()) ? got_q[i] : 'x;
        n_cmp++; if (g !== exp_q[i]) begin n_bad++; $display("FAIL t6_x[%0d][%0d]: got %h want %h", r, i, g, exp_q[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    lat_lo = 1; lat_hi = 2; hold_hi = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < VL; i++) vec[i] = $urandom_range(32'h1FFF_FFFF, 0) - 32'h1000_0000;
      run_vector(0);
      n_cmp++; if (max_q !== exp_max) begin n_bad++; $display("FAIL b2b_max[%0d]: got %h want %h", r, max_q, exp_max); end
      n_cmp++; if (n_start != VL || n_row != 1 || tmo) begin n_bad++; $display("FAIL b2b_counts[%0d]: got starts %0d rows %0d want %0d/1", r, n_start, n_row, VL); end
      for (int i = 0; i < VL; i++) begin
        logic [W-1:0] g;
        g = (i < got_q.size()) ? got_q[i] : 'x;
        n_cmp++; if (g !== exp_q[i]) begin n_bad++; $display("FAIL b2b_x[%0d][%0d]: got %h want %h", r, i, g, exp_q[i]); end
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_ties();
    test_saturate();
    test_exp_latency();
    test_reset_mid();
    test_input_gaps();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
